// File: rtl/flux_sched_pkg.sv
// Shared types and helpers for the round-robin flux scheduler.
package flux_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        ARB  = 2'd2
    } state_t;

    // Burst counter must be able to hold the value BURST itself.
    function automatic int cnt_width(input int burst);
        return $clog2(burst + 1);
    endfunction

endpackage

// File: rtl/flux_rr_pick.sv
// Combinational rotating-priority finder: keeps the current flux when the
// override is set, otherwise the first eligible flux at or after start.
module flux_rr_pick
    import flux_sched_pkg::*;
#(
    parameter int FLUX      = 2,
    parameter int TAG_WIDTH = $clog2(FLUX)
) (
    input  logic [FLUX-1:0]      elig,
    input  logic [TAG_WIDTH-1:0] start,
    input  logic                 keep,
    input  logic [TAG_WIDTH-1:0] keep_idx,
    output logic                 valid,
    output logic [TAG_WIDTH-1:0] idx
);

    // Walk start, start+1, ... so the lowest rotated offset wins; start-1 (== cur) is last.
    always_comb begin
        logic [TAG_WIDTH-1:0] pos_v;
        logic                 hit_v;
        pos_v = '0;
        hit_v = 1'b0;
        valid = keep;
        idx   = keep_idx;
        for (int k = 0; k < FLUX; k++) begin
            pos_v = TAG_WIDTH'((int'(start) + k) % FLUX);
            hit_v = elig[pos_v] && !valid;
            idx   = hit_v ? pos_v : idx;
            valid = valid | elig[pos_v];
        end
    end

endmodule

// File: rtl/flux_rr_scheduler.sv
// Burst-limited round-robin flux scheduler with a post-reset RAM priming pass.
module flux_rr_scheduler
    import flux_sched_pkg::*;
#(
    parameter int FLUX      = 2,
    parameter int BURST     = 4,
    parameter int TAG_WIDTH = $clog2(FLUX)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLUX-1:0]      empty,
    input  logic [FLUX-1:0]      full,
    output logic [FLUX-1:0]      read,
    output logic                 write,
    output logic [TAG_WIDTH-1:0] tag,
    output logic                 mem_init_en,
    output logic [TAG_WIDTH-1:0] mem_init_addr,
    output logic                 init_done
);

    localparam int                   CW         = cnt_width(BURST);
    localparam logic [CW-1:0]        BURST_C    = CW'(BURST);
    localparam logic [TAG_WIDTH-1:0] LAST_C     = TAG_WIDTH'(FLUX - 1);
    localparam logic [FLUX-1:0]      ONE_HOT_C  = FLUX'(1);

    state_t               st_r, st_nxt_s;
    logic [TAG_WIDTH-1:0] idx_r, idx_nxt_s;
    logic [TAG_WIDTH-1:0] cur_r, cur_nxt_s;
    logic [CW-1:0]        cnt_r, cnt_nxt_s;
    logic [FLUX-1:0]      elig_s;
    logic [TAG_WIDTH-1:0] start_s;
    logic                 keep_s;
    logic                 pick_valid_s;
    logic [TAG_WIDTH-1:0] pick_idx_s;

    assign elig_s  = ~empty & ~full;
    assign keep_s  = elig_s[cur_r] && (cnt_r < BURST_C);
    assign start_s = (cur_r == LAST_C) ? '0 : cur_r + TAG_WIDTH'(1);

    flux_rr_pick #(
        .FLUX      (FLUX),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_pick (
        .elig     (elig_s),
        .start    (start_s),
        .keep     (keep_s),
        .keep_idx (cur_r),
        .valid    (pick_valid_s),
        .idx      (pick_idx_s)
    );

    // State, priming index and burst bookkeeping registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_r  <= IDLE;
            idx_r <= '0;
            cur_r <= '0;
            cnt_r <= '0;
        end else begin
            st_r  <= st_nxt_s;
            idx_r <= idx_nxt_s;
            cur_r <= cur_nxt_s;
            cnt_r <= cnt_nxt_s;
        end
    end

    // Next-state and output decode; grant outputs are combinational for zero latency.
    always_comb begin
        st_nxt_s      = st_r;
        idx_nxt_s     = idx_r;
        cur_nxt_s     = cur_r;
        cnt_nxt_s     = cnt_r;
        read          = '0;
        write         = 1'b0;
        tag           = '0;
        mem_init_en   = 1'b0;
        mem_init_addr = '0;
        init_done     = 1'b0;
        case (st_r)
            IDLE: begin
                st_nxt_s  = INIT;
                idx_nxt_s = '0;
            end
            INIT: begin
                mem_init_en   = 1'b1;
                mem_init_addr = idx_r;
                if (idx_r == LAST_C) begin
                    st_nxt_s  = ARB;
                    idx_nxt_s = '0;
                end else begin
                    idx_nxt_s = idx_r + TAG_WIDTH'(1);
                end
            end
            ARB: begin
                init_done = 1'b1;
                if (pick_valid_s) begin
                    read  = ONE_HOT_C << pick_idx_s;
                    write = 1'b1;
                    tag   = pick_idx_s;
                    if (keep_s) begin
                        cnt_nxt_s = cnt_r + CW'(1);
                    end else begin
                        cur_nxt_s = pick_idx_s;
                        cnt_nxt_s = CW'(1);
                    end
                end else begin
                    cur_nxt_s = cur_r;
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                st_nxt_s  = IDLE;
                idx_nxt_s = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_flux_rr_scheduler.sv
// Scoreboard bench for flux_rr_scheduler with FLUX=4, BURST=2.
module tb_flux_rr_scheduler;

    localparam int FLUX  = 4;
    localparam int BURST = 2;
    localparam int TW    = 2;

    typedef struct packed {
        logic [3:0] read;
        logic       write;
        logic [1:0] tag;
        logic       init_en;
        logic [1:0] addr;
        logic       done;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    empty = 4'b1111;
    logic [3:0]    full  = 4'b0000;
    logic [3:0]    read;
    logic          write;
    logic [TW-1:0] tag;
    logic          mem_init_en;
    logic [TW-1:0] mem_init_addr;
    logic          init_done;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    flux_rr_scheduler #(
        .FLUX  (FLUX),
        .BURST (BURST)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .empty         (empty),
        .full          (full),
        .read          (read),
        .write         (write),
        .tag           (tag),
        .mem_init_en   (mem_init_en),
        .mem_init_addr (mem_init_addr),
        .init_done     (init_done)
    );

    task automatic check_val(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h at %0t", name, obs, exp, $time);
        end
    endtask

    // Called at posedge+1: drive flags, queue expectation, compare at negedge, return at next posedge+1.
    task automatic cyc(input logic [3:0] e, input logic [3:0] f, input exp_t x, input string name);
        exp_t got;
        empty = e;
        full  = f;
        exp_q.push_back(x);
        @(negedge clk);
        got = exp_q.pop_front();
        check_val({name, ".read"},  {28'd0, read},  {28'd0, got.read});
        check_val({name, ".write"}, {31'd0, write}, {31'd0, got.write});
        check_val({name, ".tag"},   {30'd0, tag},   {30'd0, got.tag});
        check_val({name, ".init"},  {28'd0, mem_init_en, mem_init_addr, init_done},
                                    {28'd0, got.init_en, got.addr, got.done});
        @(posedge clk);
        #1;
    endtask

    task automatic arb_cyc(input logic [3:0] e, input logic [3:0] f, input logic g,
                           input logic [1:0] t, input string name);
        exp_t x;
        logic [3:0] one;
        one = 4'b0001;
        x = '0;
        x.done = 1'b1;
        if (g) begin
            x.read  = one << t;
            x.write = 1'b1;
            x.tag   = t;
        end else begin
            x.read = 4'b0000;
        end
        cyc(e, f, x, name);
    endtask

    // Reset (checked mid-cycle), release, one idle cycle, then the four priming cycles.
    task automatic do_reset(input string name);
        exp_t x;
        rst = 1'b0;
        #1;
        check_val({name, ".async_read"},  {28'd0, read}, 32'd0);
        check_val({name, ".async_write"}, {31'd0, write}, 32'd0);
        x = '0;
        cyc(4'b0000, 4'b0000, x, {name, ".held"});
        rst = 1'b1;
        cyc(4'b0000, 4'b0000, x, {name, ".idle"});
        for (int a = 0; a < 4; a++) begin
            x = '0;
            x.init_en = 1'b1;
            x.addr    = 2'(a);
            cyc(4'b0000, 4'b0000, x, {name, ".prime"});
        end
    endtask

    initial begin
        logic [1:0] seq_all  [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
        logic [1:0] seq_full1[8]  = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
        logic [1:0] seq_resume[4] = '{2'd3, 2'd0, 2'd0, 2'd3};

        @(posedge clk);
        #1;
        do_reset("rst0");

        // All eligible: first grant immediately follows priming.
        for (int i = 0; i < 10; i++) arb_cyc(4'b0000, 4'b0000, 1'b1, seq_all[i], "all_elig");

        // Only flux 2 eligible: granted every cycle across burst expiry.
        for (int i = 0; i < 5; i++) arb_cyc(4'b1011, 4'b0000, 1'b1, 2'd2, "only2");

        do_reset("rst1");
        for (int i = 0; i < 8; i++) arb_cyc(4'b0000, 4'b0010, 1'b1, seq_full1[i], "full1");

        do_reset("rst2");
        for (int i = 0; i < 7; i++) arb_cyc(4'b0000, 4'b0000, 1'b1, seq_all[i], "pre_burst3");
        for (int i = 0; i < 3; i++) arb_cyc(4'b1111, 4'b0000, 1'b0, 2'd0, "all_empty");
        for (int i = 0; i < 4; i++) arb_cyc(4'b0110, 4'b0000, 1'b1, seq_resume[i], "resume3");

        // Reset during ARB: outputs drop at once and priming repeats.
        do_reset("rst_arb");
        arb_cyc(4'b0000, 4'b0000, 1'b1, 2'd0, "post_rst");

        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
